// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the central sequencer.
// The datapath side drives hazard/resource conditions and consumes the
// per-stage stall/flush strobes plus the divider status pulses.
interface pipeline_ctrl_if;
  logic [4:0] id_rs_i;
  logic [4:0] id_rt_i;
  logic       id_branch_stall_i;
  logic       ex_rmem_i;
  logic [4:0] ex_waddr_i;
  logic       ex_div_start_i;
  logic       mem_req_i;
  logic       mem_ack_i;
  logic       exc_valid_i;
  logic [4:0] stall_o;
  logic [4:0] flush_o;
  logic       div_busy_o;
  logic       div_done_o;
  logic       div_abort_o;
  logic [1:0] state_o;

  // Datapath side: raises conditions, obeys strobes.
  modport master (
    output id_rs_i, id_rt_i, id_branch_stall_i, ex_rmem_i, ex_waddr_i,
           ex_div_start_i, mem_req_i, mem_ack_i, exc_valid_i,
    input  stall_o, flush_o, div_busy_o, div_done_o, div_abort_o, state_o
  );

  // Sequencer side.
  modport slave (
    input  id_rs_i, id_rt_i, id_branch_stall_i, ex_rmem_i, ex_waddr_i,
           ex_div_start_i, mem_req_i, mem_ack_i, exc_valid_i,
    output stall_o, flush_o, div_busy_o, div_done_o, div_abort_o, state_o
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Central pipeline sequencer for the five-stage core. Combines hazard and
// resource conditions into per-stage stall/flush strobes, bit order
// {WB,MEM,EX,ID,IF}. Owns the divider occupancy counter, the data-memory
// wait state and the two-cycle exception flush sequence.
// Priority: exception > memory wait > divide > load-use > branch stall.
module pipeline_ctrl #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  pipeline_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DIV_WAIT  = 2'd1,
    MEM_WAIT  = 2'd2,
    EXC_FLUSH = 2'd3
  } state_t;

  // Counter reload: start cycle plus DIV_CYCLES-1 waiting cycles.
  localparam logic [4:0] DIV_LOAD = 5'(DIV_CYCLES - 1);

  // Strobe patterns; a stalled stage followed by a running one flushes it.
  localparam logic [4:0] STALL_MEM   = 5'b01111;
  localparam logic [4:0] FLUSH_MEM   = 5'b10000;
  localparam logic [4:0] STALL_DIV   = 5'b00111;
  localparam logic [4:0] FLUSH_DIV   = 5'b01000;
  localparam logic [4:0] STALL_ID    = 5'b00011;
  localparam logic [4:0] FLUSH_ID    = 5'b00100;
  localparam logic [4:0] FLUSH_EXC   = 5'b01111;
  localparam logic [4:0] FLUSH_FETCH = 5'b00001;

  state_t     r_state;
  logic [4:0] r_cnt;

  state_t     w_next_state;
  logic [4:0] w_next_cnt;
  logic [4:0] w_stall;
  logic [4:0] w_flush;
  logic       w_busy;
  logic       w_done;
  logic       w_abort;
  logic       w_load_use;
  logic       w_mem_stall;

  // Load in EX writes a register the ID instruction reads; $0 never hazards.
  assign w_load_use = bus.ex_rmem_i && (bus.ex_waddr_i != 5'd0) &&
                      ((bus.ex_waddr_i == bus.id_rs_i) ||
                       (bus.ex_waddr_i == bus.id_rt_i));

  assign w_mem_stall = bus.mem_req_i && !bus.mem_ack_i;

  // Decode current state and conditions into strobes and next state.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_stall      = '0;
    w_flush      = '0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    w_abort      = 1'b0;

    if (bus.exc_valid_i) begin
      // Exception wins from any state, including a restart in EXC_FLUSH.
      w_flush      = FLUSH_EXC;
      w_next_state = EXC_FLUSH;
      w_next_cnt   = '0;
      w_abort      = (r_state == DIV_WAIT);
    end else begin
      unique case (r_state)
        RUN: begin
          if (w_mem_stall) begin
            w_stall      = STALL_MEM;
            w_flush      = FLUSH_MEM;
            w_next_state = MEM_WAIT;
          end else if (bus.ex_div_start_i) begin
            w_stall      = STALL_DIV;
            w_flush      = FLUSH_DIV;
            w_busy       = 1'b1;
            w_next_cnt   = DIV_LOAD;
            w_next_state = DIV_WAIT;
          end else if (w_load_use || bus.id_branch_stall_i) begin
            w_stall = STALL_ID;
            w_flush = FLUSH_ID;
          end
        end
        MEM_WAIT: begin
          if (!bus.mem_ack_i) begin
            w_stall = STALL_MEM;
            w_flush = FLUSH_MEM;
          end else begin
            w_next_state = RUN;
          end
        end
        DIV_WAIT: begin
          // New divide starts are ignored here, done cycle included.
          if (r_cnt != 5'd0) begin
            w_stall    = STALL_DIV;
            w_flush    = FLUSH_DIV;
            w_busy     = 1'b1;
            w_next_cnt = r_cnt - 5'd1;
          end else begin
            w_done       = 1'b1;
            w_next_state = RUN;
          end
        end
        EXC_FLUSH: begin
          // Kill the wrong-path fetch, then resume unconditionally.
          w_flush      = FLUSH_FETCH;
          w_next_state = RUN;
        end
        default: w_next_state = RUN;
      endcase
    end
  end

  // State and divider counter registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // NOTE: outputs are masked by reset so they drop at once even while
  // upstream conditions are still asserted; no abort pulse on reset.
  assign bus.stall_o     = rst_i ? w_stall : '0;
  assign bus.flush_o     = rst_i ? w_flush : '0;
  assign bus.div_busy_o  = rst_i && w_busy;
  assign bus.div_done_o  = rst_i && w_done;
  assign bus.div_abort_o = rst_i && w_abort;
  assign bus.state_o     = rst_i ? r_state : RUN;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with DIV_CYCLES=32. Inputs change 1ns
// after the rising edge; outputs are compared on the falling edge.
module tb_pipeline_ctrl;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pipeline_ctrl_if bus ();

  pipeline_ctrl #(.DIV_CYCLES(32)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // Observation vector: {state, stall, flush, busy, done, abort}.
  logic [14:0] obs;
  assign obs = {bus.state_o, bus.stall_o, bus.flush_o,
                bus.div_busy_o, bus.div_done_o, bus.div_abort_o};

  function automatic logic [14:0] ex(input logic [1:0] st, input logic [4:0] s,
                                     input logic [4:0] f, input logic b,
                                     input logic d, input logic a);
    return {st, s, f, b, d, a};
  endfunction

  task automatic clear_inputs();
    bus.id_rs_i           = 5'd0;
    bus.id_rt_i           = 5'd0;
    bus.id_branch_stall_i = 1'b0;
    bus.ex_rmem_i         = 1'b0;
    bus.ex_waddr_i        = 5'd0;
    bus.ex_div_start_i    = 1'b0;
    bus.mem_req_i         = 1'b0;
    bus.mem_ack_i         = 1'b0;
    bus.exc_valid_i       = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    logic [14:0] e;
    clear_inputs();
    #3;
    e = '0;
    checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_idle: got %b expected %b", obs, e); end
    // Load-use condition present while in reset must not leak out.
    bus.ex_rmem_i = 1'b1; bus.ex_waddr_i = 5'd5; bus.id_rs_i = 5'd5; bus.mem_req_i = 1'b1;
    #1;
    checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_masked: got %b expected %b", obs, e); end
    clear_inputs();
    cyc();
    rst_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_release: got %b expected %b", obs, e); end
    cyc();
  endtask

  task automatic test_load_use();
    logic [14:0] e;
    e = ex(2'd0, 5'b00011, 5'b00100, 1'b0, 1'b0, 1'b0);
    bus.ex_rmem_i = 1'b1; bus.ex_waddr_i = 5'd5; bus.id_rs_i = 5'd5; bus.id_rt_i = 5'd0;
    @(negedge clk_i); checks++;
    if (obs !== e) begin errors++; $display("FAIL load_use_rs: got %b expected %b", obs, e); end
    cyc();
    bus.id_rs_i = 5'd0; bus.id_rt_i = 5'd5;
    @(negedge clk_i); checks++;
    if (obs !== e) begin errors++; $display("FAIL load_use_rt: got %b expected %b", obs, e); end
    cyc();
    bus.ex_waddr_i = 5'd0; bus.id_rs_i = 5'd0; bus.id_rt_i = 5'd0;
    @(negedge clk_i); checks++;
    if (obs !== 15'd0) begin errors++; $display("FAIL load_use_r0: got %b expected %b", obs, 15'd0); end
    cyc();
    bus.ex_rmem_i = 1'b0; bus.ex_waddr_i = 5'd5; bus.id_rs_i = 5'd5;
    @(negedge clk_i); checks++;
    if (obs !== 15'd0) begin errors++; $display("FAIL load_use_not_load: got %b expected %b", obs, 15'd0); end
    cyc();
    bus.ex_rmem_i = 1'b1; bus.ex_waddr_i = 5'd7; bus.id_rs_i = 5'd6; bus.id_rt_i = 5'd8;
    @(negedge clk_i); checks++;
    if (obs !== 15'd0) begin errors++; $display("FAIL load_use_no_match: got %b expected %b", obs, 15'd0); end
    cyc();
    clear_inputs();
    bus.id_branch_stall_i = 1'b1;
    @(negedge clk_i); checks++;
    if (obs !== e) begin errors++; $display("FAIL branch_stall: got %b expected %b", obs, e); end
    cyc();
    clear_inputs();
    @(negedge clk_i); checks++;
    if (obs !== 15'd0) begin errors++; $display("FAIL load_use_after: got %b expected %b", obs, 15'd0); end
    cyc();
  endtask

  task automatic test_divide();
    logic [14:0] e_run;
    logic [14:0] e_wait;
    logic [14:0] e_done;
    e_run  = ex(2'd0, 5'b00111, 5'b01000, 1'b1, 1'b0, 1'b0);
    e_wait = ex(2'd1, 5'b00111, 5'b01000, 1'b1, 1'b0, 1'b0);
    e_done = ex(2'd1, 5'b00000, 5'b00000, 1'b0, 1'b1, 1'b0);
    bus.ex_div_start_i = 1'b1;
    @(negedge clk_i); checks++;
    if (obs !== e_run) begin errors++; $display("FAIL div_start: got %b expected %b", obs, e_run); end
    cyc();
    for (int i = 1; i < 32; i++) begin
      @(negedge clk_i); checks++;
      if (obs !== e_wait) begin errors++; $display("FAIL div_wait_%0d: got %b expected %b", i, obs, e_wait); end
      cyc();
    end
    @(negedge clk_i); checks++;
    if (obs !== e_done) begin errors++; $display("FAIL div_done: got %b expected %b", obs, e_done); end
    cyc();
    bus.ex_div_start_i = 1'b0;
    @(negedge clk_i); checks++;
    if (obs !== 15'd0) begin errors++; $display("FAIL div_back_to_run: got %b expected %b", obs, 15'd0); end
    cyc();
  endtask

  task automatic test_mem_wait();
    logic [14:0] e_run;
    logic [14:0] e_wait;
    logic [14:0] e_ack;
    e_run  = ex(2'd0, 5'b01111, 5'b10000, 1'b0, 1'b0, 1'b0);
    e_wait = ex(2'd2, 5'b01111, 5'b10000, 1'b0, 1'b0, 1'b0);
    e_ack  = ex(2'd2, 5'b00000, 5'b00000, 1'b0, 1'b0, 1'b0);
    bus.mem_req_i = 1'b1; bus.mem_ack_i = 1'b0;
    @(negedge clk_i); checks++;
    if (obs !== e_run) begin errors++; $display("FAIL mem_first: got %b expected %b", obs, e_run); end
    cyc();
    for (int i = 1; i < 3; i++) begin
      @(negedge clk_i); checks++;
      if (obs !== e_wait) begin errors++; $display("FAIL mem_wait_%0d: got %b expected %b", i, obs, e_wait); end
      cyc();
    end
    bus.mem_ack_i = 1'b1;
    @(negedge clk_i); checks++;
    if (obs !== e_ack) begin errors++; $display("FAIL mem_ack: got %b expected %b", obs, e_ack); end
    cyc();
    // Request and ack together: zero-cycle penalty, stays in RUN.
    bus.mem_req_i = 1'b1; bus.mem_ack_i = 1'b1;
    @(negedge clk_i); checks++;
    if (obs !== 15'd0) begin errors++; $display("FAIL mem_same_cycle: got %b expected %b", obs, 15'd0); end
    cyc();
    clear_inputs();
    @(negedge clk_i); checks++;
    if (obs !== 15'd0) begin errors++; $display("FAIL mem_after: got %b expected %b", obs, 15'd0); end
    cyc();
  endtask

  task automatic test_priority();
    logic [14:0] e;
    bus.mem_req_i = 1'b1; bus.mem_ack_i = 1'b0; bus.ex_div_start_i = 1'b1;
    bus.ex_rmem_i = 1'b1; bus.ex_waddr_i = 5'd9; bus.id_rt_i = 5'd9;
    e = ex(2'd0, 5'b01111, 5'b10000, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i); checks++;
    if (obs !== e) begin errors++; $display("FAIL prio_mem_first: got %b expected %b", obs, e); end
    cyc();
    e = ex(2'd2, 5'b01111, 5'b10000, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i); checks++;
    if (obs !== e) begin errors++; $display("FAIL prio_mem_wait: got %b expected %b", obs, e); end
    cyc();
    bus.mem_ack_i = 1'b1;
    e = ex(2'd2, 5'b00000, 5'b00000, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i); checks++;
    if (obs !== e) begin errors++; $display("FAIL prio_mem_ack: got %b expected %b", obs, e); end
    cyc();
    bus.mem_req_i = 1'b0; bus.mem_ack_i = 1'b0;
    e = ex(2'd0, 5'b00111, 5'b01000, 1'b1, 1'b0, 1'b0);
    @(negedge clk_i); checks++;
    if (obs !== e) begin errors++; $display("FAIL prio_div_over_load_use: got %b expected %b", obs, e); end
    cyc();
    bus.ex_div_start_i = 1'b0;
    e = ex(2'd1, 5'b00111, 5'b01000, 1'b1, 1'b0, 1'b0);
    @(negedge clk_i); checks++;
    if (obs !== e) begin errors++; $display("FAIL prio_div_wait: got %b expected %b", obs, e); end
    cyc();
    clear_inputs();
    for (int i = 0; i < 30; i++) cyc();
    e = ex(2'd1, 5'b00000, 5'b00000, 1'b0, 1'b1, 1'b0);
    @(negedge clk_i); checks++;
    if (obs !== e) begin errors++; $display("FAIL prio_div_done: got %b expected %b", obs, e); end
    cyc();
  endtask

  task automatic test_exception_div();
    logic [14:0] e;
    logic        done_seen;
    bus.ex_div_start_i = 1'b1;
    cyc();
    bus.ex_div_start_i = 1'b0;
    for (int k = 1; k < 22; k++) cyc();
    bus.exc_valid_i = 1'b1;
    @(negedge clk_i); checks++;
    if (dut.r_cnt !== 5'd10) begin errors++; $display("FAIL exc_cnt: got %0d expected %0d", dut.r_cnt, 10); end
    e = ex(2'd1, 5'b00000, 5'b01111, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL exc_abort: got %b expected %b", obs, e); end
    cyc();
    bus.exc_valid_i = 1'b0;
    e = ex(2'd3, 5'b00000, 5'b00001, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i); checks++;
    if (obs !== e) begin errors++; $display("FAIL exc_flush: got %b expected %b", obs, e); end
    cyc();
    @(negedge clk_i); checks++;
    if (obs !== 15'd0) begin errors++; $display("FAIL exc_back_to_run: got %b expected %b", obs, 15'd0); end
    done_seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      cyc();
      @(negedge clk_i);
      done_seen = done_seen | bus.div_done_o | bus.div_busy_o;
    end
    checks++;
    if (done_seen !== 1'b0) begin errors++; $display("FAIL exc_no_done: got %b expected %b", done_seen, 1'b0); end
    cyc();
  endtask

  task automatic test_exception_restart();
    logic [14:0] e;
    // Exception outranks a pending memory wait.
    bus.exc_valid_i = 1'b1; bus.mem_req_i = 1'b1; bus.mem_ack_i = 1'b0;
    e = ex(2'd0, 5'b00000, 5'b01111, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i); checks++;
    if (obs !== e) begin errors++; $display("FAIL exc_over_mem: got %b expected %b", obs, e); end
    cyc();
    bus.mem_req_i = 1'b0;
    e = ex(2'd3, 5'b00000, 5'b01111, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i); checks++;
    if (obs !== e) begin errors++; $display("FAIL exc_restart: got %b expected %b", obs, e); end
    cyc();
    bus.exc_valid_i = 1'b0;
    e = ex(2'd3, 5'b00000, 5'b00001, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i); checks++;
    if (obs !== e) begin errors++; $display("FAIL exc_restart_flush: got %b expected %b", obs, e); end
    cyc();
    @(negedge clk_i); checks++;
    if (obs !== 15'd0) begin errors++; $display("FAIL exc_restart_run: got %b expected %b", obs, 15'd0); end
    cyc();
  endtask

  task automatic test_reset_mid_op();
    logic [14:0] e;
    bus.mem_req_i = 1'b1; bus.mem_ack_i = 1'b0;
    cyc();
    e = ex(2'd2, 5'b01111, 5'b10000, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i); checks++;
    if (obs !== e) begin errors++; $display("FAIL rst_mem_pre: got %b expected %b", obs, e); end
    #2 rst_i = 1'b0;
    #1; checks++;
    if (obs !== 15'd0) begin errors++; $display("FAIL rst_mem_async: got %b expected %b", obs, 15'd0); end
    cyc();
    clear_inputs();
    rst_i = 1'b1;
    @(negedge clk_i); checks++;
    if (obs !== 15'd0) begin errors++; $display("FAIL rst_mem_state: got %b expected %b", obs, 15'd0); end
    cyc();
    bus.ex_rmem_i = 1'b1; bus.ex_waddr_i = 5'd3; bus.id_rs_i = 5'd3;
    e = ex(2'd0, 5'b00011, 5'b00100, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i); checks++;
    if (obs !== e) begin errors++; $display("FAIL rst_normal_after: got %b expected %b", obs, e); end
    cyc();
    // Reset mid-divide: silent abort.
    clear_inputs();
    bus.ex_div_start_i = 1'b1;
    cyc();
    bus.ex_div_start_i = 1'b0;
    cyc();
    cyc();
    #2 rst_i = 1'b0;
    #1; checks++;
    if (obs !== 15'd0) begin errors++; $display("FAIL rst_div_silent: got %b expected %b", obs, 15'd0); end
    cyc();
    rst_i = 1'b1;
    @(negedge clk_i); checks++;
    if (obs !== 15'd0) begin errors++; $display("FAIL rst_div_state: got %b expected %b", obs, 15'd0); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_divide();
    test_mem_wait();
    test_priority();
    test_exception_div();
    test_exception_restart();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
